// File: rtl/sp_bram_req_ctrl.sv
// Request/response front end for a single-port write-first block RAM.
// Issues one-cycle RAM accesses and returns results in order through a response FIFO.
module sp_bram_req_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SETS   = 1024,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [$clog2(NUM_SETS)-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]         req_wdata_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_we_o,
    output logic                          rsp_err_o,
    output logic                          mem_chip_en_o,
    output logic                          mem_wr_en_o,
    output logic [$clog2(NUM_SETS)-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wr_data_o,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data_i
);

    localparam int unsigned AW = $clog2(NUM_SETS);
    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  fifo_we_q, fifo_we_d;
    logic [RSP_DEPTH-1:0]  fifo_err_q, fifo_err_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_we_q, inflight_we_d;
    logic                  inflight_err_q, inflight_err_d;

    logic                  in_range;
    logic                  fire;
    logic                  push;
    logic                  pop;
    logic [CW:0]           occupancy;

    // Limit is one bit wider than the address so a power-of-two depth still compares correctly.
    assign in_range  = ({1'b0, req_addr_i} < (AW + 1)'(NUM_SETS));
    assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q);

    assign req_ready_o = (occupancy < (CW + 1)'(RSP_DEPTH));
    // Reset gates the handshake so nothing reaches the RAM while rst_ni is low.
    assign fire = req_valid_i & req_ready_o & rst_ni;

    assign mem_chip_en_o = fire & in_range;
    assign mem_wr_en_o   = fire & in_range & req_we_i;
    assign mem_addr_o    = fire ? req_addr_i  : '0;
    assign mem_wr_data_o = fire ? req_wdata_i : '0;

    assign push = inflight_q;
    assign pop  = rsp_valid_o & rsp_ready_i;

    assign rsp_valid_o = (count_q != '0);
    assign rsp_rdata_o = rsp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    assign rsp_we_o    = rsp_valid_o & fifo_we_q[rd_ptr_q];
    assign rsp_err_o   = rsp_valid_o & fifo_err_q[rd_ptr_q];

    always_comb begin
        inflight_d     = fire;
        inflight_we_d  = fire & req_we_i;
        inflight_err_d = fire & ~in_range;

        fifo_data_d = fifo_data_q;
        fifo_we_d   = fifo_we_q;
        fifo_err_d  = fifo_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (push) begin
            fifo_data_d[wr_ptr_q] = inflight_err_q ? '0 : mem_rd_data_i;
            fifo_we_d[wr_ptr_q]   = inflight_we_q;
            fifo_err_d[wr_ptr_q]  = inflight_err_q;
            wr_ptr_d = (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            inflight_q     <= 1'b0;
            inflight_we_q  <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            inflight_q     <= inflight_d;
            inflight_we_q  <= inflight_we_d;
            inflight_err_q <= inflight_err_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_we_q   <= fifo_we_d;
        fifo_err_q  <= fifo_err_d;
    end

    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_ni)
        push |-> (count_q != CW'(RSP_DEPTH)));

    a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_ni)
        pop |-> (count_q != '0));

    a_req_stable : assert property (@(posedge clk) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=> $stable({req_we_i, req_addr_i, req_wdata_i}));

endmodule

// File: tb/tb_sp_bram_req_ctrl.sv
// Directed bench for sp_bram_req_ctrl with a write-first RAM model and an in-order response scoreboard.
module tb_sp_bram_req_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 1000;
    localparam int unsigned RD = 4;
    localparam int unsigned AW = $clog2(NS);

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_we_o;
    logic          rsp_err_o;
    logic          mem_chip_en_o;
    logic          mem_wr_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wr_data_o;
    logic [DW-1:0] mem_rd_data_i = '0;

    always #5 clk = ~clk;

    sp_bram_req_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_SETS   (NS),
        .RSP_DEPTH  (RD)
    ) dut (
        .clk           (clk),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_we_o      (rsp_we_o),
        .rsp_err_o     (rsp_err_o),
        .mem_chip_en_o (mem_chip_en_o),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wr_data_o (mem_wr_data_o),
        .mem_rd_data_i (mem_rd_data_i)
    );

    // Write-first single-port RAM model
    logic [DW-1:0] ram [1024];
    always_ff @(posedge clk) begin
        if (mem_chip_en_o) begin
            if (mem_wr_en_o) begin
                ram[mem_addr_o] <= mem_wr_data_o;
                mem_rd_data_i   <= mem_wr_data_o;
            end else begin
                mem_rd_data_i <= ram[mem_addr_o];
            end
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_issued = 0;
    int unsigned n_rsp    = 0;
    logic [DW+1:0] exp_q [$];
    logic [DW+1:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: sampled 2 time units after the negedge, once rsp_ready_i has settled.
    always begin
        @(negedge clk);
        #2;
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check("rsp_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp", {rsp_we_o, rsp_err_o, rsp_rdata_o}, mon_exp);
                n_rsp++;
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic err, input logic [DW-1:0] exp_data,
                        output int unsigned stalls);
        stalls = 0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wd;
        #1;
        while (!req_ready_o && stalls < 64) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!req_ready_o) begin
            check("req_timeout", 64'(req_ready_o), 64'd1);
        end else begin
            check("mem_ce", 64'(mem_chip_en_o), 64'(!err));
            check("mem_we", 64'(mem_wr_en_o), 64'(we & !err));
            check("mem_addr", 64'(mem_addr_o), 64'(addr));
            check("mem_wdata", 64'(mem_wr_data_o), 64'(wd));
            exp_q.push_back({we, err, exp_data});
            n_issued++;
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || rsp_valid_o) && n < 60) begin
            idle();
            #3;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned st;
        int unsigned stall_sum;

        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;

        // Reset: request offered during reset must not reach the RAM
        repeat (3) @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 10'd7;
        req_wdata_i = 32'h1234_5678;
        #1;
        check("rst_mem_ce", 64'(mem_chip_en_o), 64'd0);
        check("rst_mem_we", 64'(mem_wr_en_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        idle();
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        check("rst_rsp_we", 64'(rsp_we_o), 64'd0);
        check("rst_rsp_err", 64'(rsp_err_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("idle_mem_ce", 64'(mem_chip_en_o), 64'd0);

        // Preload addresses 0..15 with addr*3, then stream them back
        stall_sum = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            send(1'b1, AW'(i), DW'(i * 3), 1'b0, DW'(i * 3), st);
            stall_sum += st;
        end
        drain();
        for (int unsigned i = 0; i < 16; i++) begin
            send(1'b0, AW'(i), '0, 1'b0, DW'(i * 3), st);
            stall_sum += st;
        end
        check("stream_stalls", 64'(stall_sum), 64'd0);
        drain();

        // Write then read addr 5 with latency checks
        send(1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, st);
        idle();
        #1;
        check("wr_lat_n1", 64'(rsp_valid_o), 64'd0);
        idle();
        #1;
        check("wr_lat_n2", 64'(rsp_valid_o), 64'd1);
        check("wr_rsp", {rsp_we_o, rsp_err_o, rsp_rdata_o}, {2'b10, 32'hDEAD_BEEF});
        send(1'b0, 10'd5, '0, 1'b0, 32'hDEAD_BEEF, st);
        idle();
        #1;
        check("rd_lat_n1", 64'(rsp_valid_o), 64'd0);
        idle();
        #1;
        check("rd_lat_n2", 64'(rsp_valid_o), 64'd1);
        check("rd_rsp", {rsp_we_o, rsp_err_o, rsp_rdata_o}, {2'b00, 32'hDEAD_BEEF});
        drain();

        // Backpressure: four accepted, fifth held until the first pop
        rsp_ready_i = 1'b0;
        stall_sum = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            send(1'b0, AW'(10 + i), '0, 1'b0, DW'((10 + i) * 3), st);
            stall_sum += st;
        end
        check("bp_accept4", 64'(stall_sum), 64'd0);
        @(negedge clk);
        req_addr_i = 10'd14;
        #1;
        check("bp_ready_low", 64'(req_ready_o), 64'd0);
        check("bp_mem_ce", 64'(mem_chip_en_o), 64'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_ready", 64'(req_ready_o), 64'd0);
            check("bp_hold_rsp", {rsp_valid_o, rsp_we_o, rsp_err_o, rsp_rdata_o}, {3'b100, 32'd30});
        end
        @(negedge clk);
        rsp_ready_i = 1'b1;
        #1;
        check("bp_ready_pop_cyc", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        #1;
        check("bp_ready_after_pop", 64'(req_ready_o), 64'd1);
        check("bp_fifth_ce", 64'(mem_chip_en_o), 64'd1);
        exp_q.push_back({2'b00, 32'd42});
        n_issued++;
        drain();

        // Out-of-range read then in-range read
        send(1'b0, 10'd1000, '0, 1'b1, '0, st);
        send(1'b0, 10'd12, '0, 1'b0, 32'd36, st);
        drain();

        // Reset with a read in flight: its response is discarded
        send(1'b0, 10'd13, '0, 1'b0, 32'd39, st);
        exp_q.delete(exp_q.size() - 1);
        n_issued--;
        @(negedge clk);
        req_valid_i = 1'b0;
        rst_ni      = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("mid_rst_valid", 64'(rsp_valid_o), 64'd0);
        check("mid_rst_ready", 64'(req_ready_o), 64'd1);
        check("mid_rst_count", 64'(dut.count_q), 64'd0);
        idle();
        idle();
        #1;
        check("mid_rst_no_rsp", 64'(rsp_valid_o), 64'd0);
        send(1'b0, 10'd5, '0, 1'b0, 32'hDEAD_BEEF, st);
        drain();

        // Full FIFO with rsp_ready_i toggling: 3*RSP_DEPTH writes then reads, wrapping pointers
        fork
            begin
                for (int unsigned i = 0; i < 3 * RD; i++) begin
                    send(1'b1, AW'(100 + i), 32'hA500_0000 + DW'(i), 1'b0, 32'hA500_0000 + DW'(i), st);
                end
                for (int unsigned i = 0; i < 3 * RD; i++) begin
                    send(1'b0, AW'(100 + i), '0, 1'b0, 32'hA500_0000 + DW'(i), st);
                end
                idle();
            end
            begin
                repeat (120) begin
                    @(negedge clk);
                    rsp_ready_i = ~rsp_ready_i;
                end
            end
        join
        rsp_ready_i = 1'b1;
        drain();
        check("rsp_total", 64'(n_rsp), 64'(n_issued));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
